// File: rtl/output_mem.sv
// Output pixel buffer: collects rotated B/G/R bytes at arbitrary addresses and emits
// completed 32-bit words in ascending order. Define OMEM_FLUSH_EN to emit partial words on I_OMEM_FLUSH.
module output_mem #(
    parameter int DEPTH_BYTES = 64,
    parameter int ADDR_W      = 6,
    parameter int PTR_W       = 4
) (
    input  logic              I_OMEM_HCLK,
    input  logic              I_OMEM_HRESET,
    input  logic              I_OMEM_CLR,
    input  logic              I_OMEM_PIXEL_VALID,
    output logic              O_OMEM_PIXEL_READY,
    input  logic [7:0]        I_OMEM_PIXEL_B,
    input  logic [7:0]        I_OMEM_PIXEL_G,
    input  logic [7:0]        I_OMEM_PIXEL_R,
    input  logic [ADDR_W-1:0] I_OMEM_PIXEL_ADDRB,
    input  logic [ADDR_W-1:0] I_OMEM_PIXEL_ADDRG,
    input  logic [ADDR_W-1:0] I_OMEM_PIXEL_ADDRR,
    input  logic              I_OMEM_FLUSH,
    output logic [31:0]       O_OMEM_WDATA,
    output logic [3:0]        O_OMEM_WSTRB,
    output logic              O_OMEM_WVALID,
    input  logic              I_OMEM_WREADY,
    output logic [PTR_W-1:0]  O_OMEM_WORD_IDX,
    output logic              O_OMEM_EMPTY
);

    logic [7:0]             mem [DEPTH_BYTES];
    logic [DEPTH_BYTES-1:0] byte_vld;
    logic [DEPTH_BYTES-1:0] byte_vld_nxt;
    logic [PTR_W-1:0]       rd_ptr;
    logic [ADDR_W-1:0]      word_base;
    logic [3:0]             cur_vld;
    logic [31:0]            word_data;
    logic                   complete;
    logic                   partial;
    logic                   reg_free;
    logic                   load;
    logic                   wr_en;

    logic [31:0]            wdata_p1;
    logic [3:0]             wstrb_p1;
    logic                   vld_p1;
    logic [PTR_W-1:0]       idx_p1;

    assign word_base = {rd_ptr, 2'b00};

    // Missing bytes of a partial word are driven as zero
    always_comb begin
        cur_vld   = 4'b0000;
        word_data = 32'h0;
        for (int k = 0; k < 4; k++) begin
            cur_vld[k]          = byte_vld[word_base + ADDR_W'(k)];
            word_data[8*k +: 8] = cur_vld[k] ? mem[word_base + ADDR_W'(k)] : 8'h00;
        end
    end

    assign complete = &cur_vld;

`ifdef OMEM_FLUSH_EN
    assign partial = I_OMEM_FLUSH & (|cur_vld) & ~complete;
`else
    logic unused_flush;
    assign unused_flush = I_OMEM_FLUSH;
    assign partial      = 1'b0;
`endif

    assign reg_free = ~vld_p1 | I_OMEM_WREADY;
    assign load     = reg_free & (complete | partial);

    assign O_OMEM_PIXEL_READY = ~byte_vld[I_OMEM_PIXEL_ADDRB] &
                                ~byte_vld[I_OMEM_PIXEL_ADDRG] &
                                ~byte_vld[I_OMEM_PIXEL_ADDRR];
    assign wr_en = I_OMEM_PIXEL_VALID & O_OMEM_PIXEL_READY & ~I_OMEM_CLR;

    always_comb begin
        byte_vld_nxt = byte_vld;
        if (load) begin
            for (int k = 0; k < 4; k++) begin
                byte_vld_nxt[word_base + ADDR_W'(k)] = 1'b0;
            end
        end
        if (wr_en) begin
            byte_vld_nxt[I_OMEM_PIXEL_ADDRB] = 1'b1;
            byte_vld_nxt[I_OMEM_PIXEL_ADDRG] = 1'b1;
            byte_vld_nxt[I_OMEM_PIXEL_ADDRR] = 1'b1;
        end
    end

    // Later assignments win on equal addresses: R over G over B
    always_ff @(posedge I_OMEM_HCLK) begin
        if (wr_en) begin
            mem[I_OMEM_PIXEL_ADDRB] <= I_OMEM_PIXEL_B;
            mem[I_OMEM_PIXEL_ADDRG] <= I_OMEM_PIXEL_G;
            mem[I_OMEM_PIXEL_ADDRR] <= I_OMEM_PIXEL_R;
        end
    end

    // Stage p1: output word register toward the AHB write master
    always_ff @(posedge I_OMEM_HCLK or posedge I_OMEM_HRESET) begin
        if (I_OMEM_HRESET) begin
            byte_vld <= '0;
            rd_ptr   <= '0;
            wdata_p1 <= 32'h0;
            wstrb_p1 <= 4'h0;
            vld_p1   <= 1'b0;
            idx_p1   <= '0;
        end else if (I_OMEM_CLR) begin
            byte_vld <= '0;
            rd_ptr   <= '0;
            wstrb_p1 <= 4'h0;
            vld_p1   <= 1'b0;
        end else begin
            byte_vld <= byte_vld_nxt;
            if (load) begin
                wdata_p1 <= word_data;
                wstrb_p1 <= cur_vld;
                idx_p1   <= rd_ptr;
                vld_p1   <= 1'b1;
                rd_ptr   <= rd_ptr + 1'b1;
            end else if (reg_free) begin
                vld_p1   <= 1'b0;
            end
        end
    end

    assign O_OMEM_WDATA    = wdata_p1;
    assign O_OMEM_WSTRB    = wstrb_p1;
    assign O_OMEM_WVALID   = vld_p1;
    assign O_OMEM_WORD_IDX = idx_p1;
    assign O_OMEM_EMPTY    = ~(|byte_vld) & ~vld_p1;

endmodule

// File: tb/tb_output_mem.sv
// Scoreboard bench for output_mem: expected words are queued at stimulus time and
// popped by a monitor on every WVALID&WREADY handshake.
module tb_output_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        pvalid;
    logic        pready;
    logic [7:0]  pb, pg, pr;
    logic [5:0]  ab, ag, ar;
    logic        flush;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [3:0]  widx;
    logic        empty;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  idx;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    output_mem dut (
        .I_OMEM_HCLK        (clk),
        .I_OMEM_HRESET      (rst),
        .I_OMEM_CLR         (clr),
        .I_OMEM_PIXEL_VALID (pvalid),
        .O_OMEM_PIXEL_READY (pready),
        .I_OMEM_PIXEL_B     (pb),
        .I_OMEM_PIXEL_G     (pg),
        .I_OMEM_PIXEL_R     (pr),
        .I_OMEM_PIXEL_ADDRB (ab),
        .I_OMEM_PIXEL_ADDRG (ag),
        .I_OMEM_PIXEL_ADDRR (ar),
        .I_OMEM_FLUSH       (flush),
        .O_OMEM_WDATA       (wdata),
        .O_OMEM_WSTRB       (wstrb),
        .O_OMEM_WVALID      (wvalid),
        .I_OMEM_WREADY      (wready),
        .O_OMEM_WORD_IDX    (widx),
        .O_OMEM_EMPTY       (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] s, input logic [3:0] i);
        exp_t e;
        e.data = d;
        e.strb = s;
        e.idx  = i;
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2);
        ab = a0;
        ag = a1;
        ar = a2;
        #0;
    endtask

    task automatic px(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r,
                      input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2);
        int n;
        pb = b; pg = g; pr = r;
        ab = a0; ag = a1; ar = a2;
        pvalid = 1'b1;
        n = 0;
        #0;
        while (!pready && n < 20) begin
            cyc(1);
            n++;
        end
        if (n == 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL pixel_ready_timeout: got ready=0 expected ready=1 addr %0d", a0);
        end
        cyc(1);
        pvalid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && wvalid && wready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got idx %0d data %h expected no word", widx, wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("word_data", wdata, e.data);
                chk("word_strb", 32'(wstrb), 32'(e.strb));
                chk("word_idx", 32'(widx), 32'(e.idx));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; pvalid = 1'b0; flush = 1'b0; wready = 1'b0;
        pb = 8'h0; pg = 8'h0; pr = 8'h0; ab = 6'd0; ag = 6'd0; ar = 6'd0;
        cyc(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wvalid", 32'(wvalid), 0);
        chk("rst_wstrb", 32'(wstrb), 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_idx", 32'(widx), 0);
        chk("rst_empty", 32'(empty), 1);
        probe(6'd17, 6'd40, 6'd63);
        chk("rst_ready", 32'(pready), 1);

        // Word 0 assembled with the output register stalled
        cyc(1);
        push(32'h44332211, 4'hF, 4'd0);
        px(8'h11, 8'h22, 8'h33, 6'd0, 6'd1, 6'd2);
        px(8'h44, 8'h55, 8'h66, 6'd3, 6'd4, 6'd5);
        @(negedge clk);
        chk("lat_wvalid_low", 32'(wvalid), 0);
        probe(6'd2, 6'd2, 6'd2);
        chk("ready_before_load", 32'(pready), 0);
        cyc(1);
        @(negedge clk);
        chk("lat_wvalid_high", 32'(wvalid), 1);
        chk("w0_data", wdata, 32'h44332211);
        chk("w0_idx", 32'(widx), 0);
        chk("ready_after_load", 32'(pready), 1);

        // Word 1 completes behind the stalled word 0
        cyc(1);
        px(8'h77, 8'h88, 8'h99, 6'd6, 6'd7, 6'd8);
        push(32'h88776655, 4'hF, 4'd1);
        cyc(3);
        @(negedge clk);
        chk("stall_data", wdata, 32'h44332211);
        chk("stall_idx", 32'(widx), 0);
        chk("stall_wvalid", 32'(wvalid), 1);
        chk("stall_empty", 32'(empty), 0);
        @(posedge clk);
        #1;
        wready = 1'b1;
        cyc(4);
        chk("b2b_drained", 32'(sb.size()), 0);

        push(32'hA3A2A199, 4'hF, 4'd2);
        px(8'hA1, 8'hA2, 8'hA3, 6'd9, 6'd10, 6'd11);
        cyc(3);

        // Words 3..15 then wrap to 0; last byte written with all three addresses equal
        for (int w = 3; w < 16; w++) begin
            logic [7:0] base;
            base = 8'(w * 16);
            push({base + 8'd3, base + 8'd2, base + 8'd1, base}, 4'hF, 4'(w));
            px(base, base + 8'd1, base + 8'd2, 6'(4*w), 6'(4*w+1), 6'(4*w+2));
            px(8'hEE, 8'hDD, base + 8'd3, 6'(4*w+3), 6'(4*w+3), 6'(4*w+3));
        end
        push(32'hC3C2C1C0, 4'hF, 4'd0);
        px(8'hC0, 8'hC1, 8'hC2, 6'd0, 6'd1, 6'd2);
        px(8'h00, 8'h00, 8'hC3, 6'd3, 6'd3, 6'd3);
        cyc(3);
        chk("wrap_drained", 32'(sb.size()), 0);

        // Partial word 1 with a flush
        px(8'hAA, 8'hBB, 8'hCC, 6'd4, 6'd5, 6'd6);
        cyc(2);
`ifdef OMEM_FLUSH_EN
        push(32'h00CCBBAA, 4'b0111, 4'd1);
`endif
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        @(negedge clk);
`ifdef OMEM_FLUSH_EN
        chk("flush_wvalid", 32'(wvalid), 1);
`else
        chk("flush_wvalid", 32'(wvalid), 0);
        cyc(1);
        push(32'hDDCCBBAA, 4'hF, 4'd1);
        px(8'h00, 8'h00, 8'hDD, 6'd7, 6'd7, 6'd7);
`endif
        cyc(3);

        // Clear with a held word and partial bytes outstanding; pixel on the clear edge is dropped
        wready = 1'b0;
        px(8'hD0, 8'hD1, 8'hD2, 6'd8, 6'd9, 6'd10);
        px(8'h00, 8'h00, 8'hD3, 6'd11, 6'd11, 6'd11);
        px(8'hE0, 8'hE1, 8'hE2, 6'd12, 6'd13, 6'd14);
        @(negedge clk);
        chk("pre_clr_wvalid", 32'(wvalid), 1);
        chk("pre_clr_idx", 32'(widx), 2);
        @(posedge clk);
        #1;
        clr = 1'b1;
        pb = 8'h55; pg = 8'h55; pr = 8'h55;
        ab = 6'd0; ag = 6'd1; ar = 6'd2;
        pvalid = 1'b1;
        cyc(1);
        clr = 1'b0;
        pvalid = 1'b0;
        @(negedge clk);
        chk("clr_wvalid", 32'(wvalid), 0);
        chk("clr_wstrb", 32'(wstrb), 0);
        chk("clr_empty", 32'(empty), 1);
        probe(6'd0, 6'd1, 6'd2);
        chk("clr_drop_ready", 32'(pready), 1);
        probe(6'd12, 6'd13, 6'd14);
        chk("clr_partial_ready", 32'(pready), 1);
        cyc(1);
        wready = 1'b1;
        push(32'hF3F2F1F0, 4'hF, 4'd0);
        px(8'hF0, 8'hF1, 8'hF2, 6'd0, 6'd1, 6'd2);
        px(8'h00, 8'h00, 8'hF3, 6'd3, 6'd3, 6'd3);
        cyc(3);

        // Asynchronous reset while a word is held and bytes are pending
        wready = 1'b0;
        px(8'h11, 8'h22, 8'h33, 6'd4, 6'd5, 6'd6);
        px(8'h00, 8'h00, 8'h44, 6'd7, 6'd7, 6'd7);
        px(8'h55, 8'h66, 8'h77, 6'd8, 6'd9, 6'd10);
        cyc(1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_wvalid", 32'(wvalid), 0);
        chk("mid_rst_wstrb", 32'(wstrb), 0);
        chk("mid_rst_wdata", wdata, 0);
        chk("mid_rst_idx", 32'(widx), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        probe(6'd8, 6'd9, 6'd10);
        chk("mid_rst_ready", 32'(pready), 1);
        #1;
        rst = 1'b0;
        cyc(1);
        wready = 1'b1;
        push(32'h04030201, 4'hF, 4'd0);
        px(8'h01, 8'h02, 8'h03, 6'd0, 6'd1, 6'd2);
        px(8'h00, 8'h00, 8'h04, 6'd3, 6'd3, 6'd3);
        cyc(4);
        chk("final_drained", 32'(sb.size()), 0);
        chk("final_empty", 32'(empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
